// File: rtl/uart_msg_arbiter.sv
// Per-message arbiter that shares one UART wishbone slave among NUM_REQ masters.
// Define UART_ARB_PREFIX_EN to have each granted message preceded by "<id>:".
module uart_msg_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int IDLE_TIMEOUT = 1000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_stb_i,
    input  logic [NUM_REQ-1:0]      req_we_i,
    input  logic [NUM_REQ-1:0]      req_addr_i,
    input  logic [4*NUM_REQ-1:0]    req_sel_i,
    input  logic [32*NUM_REQ-1:0]   req_dat_i,
    output logic [NUM_REQ-1:0]      req_ack_o,
    output logic [31:0]             req_dat_o,
    output logic                    m_stb_o,
    output logic                    m_cyc_o,
    output logic                    m_we_o,
    output logic                    m_addr_o,
    output logic [3:0]              m_sel_o,
    output logic [31:0]             m_dat_o,
    input  logic [31:0]             m_dat_i,
    input  logic                    m_ack_i,
    output logic [1:0]              fsm_state
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_LAST  = CW'((IDLE_TIMEOUT > 0) ? IDLE_TIMEOUT - 1 : 0);
    localparam logic [IW:0]   NUM_W    = (IW + 1)'(NUM_REQ);
    localparam logic [IW-1:0] LAST_REQ = IW'(NUM_REQ - 1);

`ifdef UART_ARB_PREFIX_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOCK = 2'd1, S_PREFIX = 2'd2} state_t;
    logic prefix_step;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOCK = 2'd1} state_t;
`endif

    state_t          state;
    logic [IW-1:0]   holder;
    logic [IW-1:0]   last_grant;
    logic [IW-1:0]   pick;
    logic            pick_valid;
    logic [CW-1:0]   idle_cnt;

    logic            h_stb;
    logic            h_we;
    logic            h_addr;
    logic [3:0]      h_sel;
    logic [31:0]     h_dat;
    logic            rel_nl;
    logic            rel_to;

    assign h_stb  = req_stb_i[holder];
    assign h_we   = req_we_i[holder];
    assign h_addr = req_addr_i[holder];
    assign h_sel  = req_sel_i[{holder, 2'b00} +: 4];
    assign h_dat  = req_dat_i[{holder, 5'b00000} +: 32];

    // A message ends on an acked newline write; reads never end it.
    assign rel_nl = h_stb & h_we & m_ack_i & (h_dat[7:0] == 8'h0A);
    assign rel_to = (IDLE_TIMEOUT != 0) && !h_stb && (idle_cnt == TO_LAST);

    assign fsm_state = state;
    assign m_cyc_o   = m_stb_o;

    // Round-robin search: walk downward so the nearest requester after last_grant wins.
    always_comb begin
        logic [IW:0] sum;
        pick       = '0;
        pick_valid = 1'b0;
        sum        = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            sum = {1'b0, last_grant} + (IW + 1)'(k);
            if (sum >= NUM_W) sum = sum - NUM_W;
            if (req_stb_i[sum[IW-1:0]]) begin
                pick       = sum[IW-1:0];
                pick_valid = 1'b1;
            end
        end
    end

    always_comb begin
        m_stb_o   = 1'b0;
        m_we_o    = 1'b0;
        m_addr_o  = 1'b0;
        m_sel_o   = 4'h0;
        m_dat_o   = 32'h0;
        req_ack_o = '0;
        req_dat_o = 32'h0;
        case (state)
            S_LOCK: begin
                m_stb_o           = h_stb;
                m_we_o            = h_we;
                m_addr_o          = h_addr;
                m_sel_o           = h_sel;
                m_dat_o           = h_dat;
                req_ack_o[holder] = m_ack_i;
                req_dat_o         = m_dat_i;
            end
`ifdef UART_ARB_PREFIX_EN
            S_PREFIX: begin
                m_stb_o  = 1'b1;
                m_we_o   = 1'b1;
                m_sel_o  = 4'h1;
                m_dat_o  = {24'h0, prefix_step ? 8'h3A : (8'h30 + 8'(holder))};
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            holder     <= '0;
            last_grant <= LAST_REQ;
            idle_cnt   <= '0;
`ifdef UART_ARB_PREFIX_EN
            prefix_step <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    idle_cnt <= '0;
                    if (pick_valid) begin
                        holder <= pick;
`ifdef UART_ARB_PREFIX_EN
                        state       <= S_PREFIX;
                        prefix_step <= 1'b0;
`else
                        state  <= S_LOCK;
`endif
                    end
                end
`ifdef UART_ARB_PREFIX_EN
                S_PREFIX: begin
                    if (m_ack_i) begin
                        if (prefix_step) begin
                            prefix_step <= 1'b0;
                            state       <= S_LOCK;
                        end else begin
                            prefix_step <= 1'b1;
                        end
                    end
                end
`endif
                S_LOCK: begin
                    if (rel_nl || rel_to) begin
                        state      <= S_IDLE;
                        last_grant <= holder;
                        idle_cnt   <= '0;
                    end else if (h_stb) begin
                        idle_cnt <= '0;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
